// File: rtl/cordic_pkg.sv
// Shared constants, state type and saturation helper
// for the iterative CORDIC rotator.
package cordic_pkg;

  localparam int ANGLE_PI      = 128;
  localparam int ANGLE_HALF_PI = ANGLE_PI / 2;
  localparam int ATW           = 8;

  // atan(2^-i) in binary-angle LSBs, 128 = pi
  localparam logic signed [ATW-1:0] ATAN [0:6] = '{
    8'sd32, 8'sd19, 8'sd10, 8'sd5, 8'sd3, 8'sd1, 8'sd1
  };

  typedef enum logic [1:0] {
    IDLE,
    ROTATE,
    DONE
  } state_e;

  function automatic logic signed [31:0] sat(
    input logic signed [31:0] v,
    input int                 w
  );
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/cordic_iter_rotator_if.sv
// Operand/result handshake bundle for the
// iterative CORDIC rotator.
interface cordic_iter_rotator_if #(
  parameter int WIDTH = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] x0;
  logic signed [WIDTH-1:0] y0;
  logic signed [WIDTH-1:0] z0;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] x_out;
  logic signed [WIDTH-1:0] y_out;
  logic                    range_err;

  modport master (
    output in_valid, x0, y0, z0, out_ready,
    input  in_ready, out_valid, x_out, y_out, range_err
  );

  modport slave (
    input  in_valid, x0, y0, z0, out_ready,
    output in_ready, out_valid, x_out, y_out, range_err
  );
endinterface

// File: rtl/cordic_micro_rot.sv
// One combinational CORDIC micro-rotation,
// reused every cycle by the iterative engine.
module cordic_micro_rot
  import cordic_pkg::*;
#(
  parameter int IW = 10,
  parameter int ZW = 8
) (
  input  logic signed [IW-1:0] i_x,
  input  logic signed [IW-1:0] i_y,
  input  logic signed [ZW-1:0] i_z,
  input  logic [2:0]           i_i,
  output logic signed [IW-1:0] o_x,
  output logic signed [IW-1:0] o_y,
  output logic signed [ZW-1:0] o_z
);

  logic signed [IW-1:0] w_xs;
  logic signed [IW-1:0] w_ys;
  logic signed [ZW-1:0] w_at;

  assign w_xs = i_x >>> i_i;
  assign w_ys = i_y >>> i_i;
  assign w_at = ZW'(ATAN[i_i]);

  always_comb begin
    o_x = i_x;
    o_y = i_y;
    o_z = i_z;
    if (!i_z[ZW-1]) begin
      o_x = i_x - w_ys;
      o_y = i_y + w_xs;
      o_z = i_z - w_at;
    end else begin
      o_x = i_x + w_ys;
      o_y = i_y - w_xs;
      o_z = i_z + w_at;
    end
  end

endmodule

// File: rtl/cordic_iter_rotator.sv
// Iterative rotation-mode CORDIC, one micro-rotation
// per clock, results on a valid/ready handshake.
module cordic_iter_rotator
  import cordic_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ITER  = 7,
  parameter int GUARD = 2
) (
  input logic                  clk,
  input logic                  rst,
  cordic_iter_rotator_if.slave b
);

  localparam int IW = WIDTH + GUARD;

  state_e r_state;
  state_e w_state_n;

  logic signed [IW-1:0]    r_x;
  logic signed [IW-1:0]    r_y;
  logic signed [WIDTH-1:0] r_z;
  logic [2:0]              r_i;
  logic signed [WIDTH-1:0] r_x_out;
  logic signed [WIDTH-1:0] r_y_out;
  logic                    r_rerr;
  logic                    r_ovalid;

  logic signed [IW-1:0]    w_x_n;
  logic signed [IW-1:0]    w_y_n;
  logic signed [WIDTH-1:0] w_z_n;
  logic signed [WIDTH-1:0] w_z_cl;
  logic                    w_clamped;
  logic                    w_acc;
  logic                    w_xfer;
  logic                    w_last;

  assign w_acc  = b.in_valid && (r_state == IDLE);
  assign w_xfer = r_ovalid && b.out_ready;
  assign w_last = (r_i == 3'(ITER - 1));

  assign b.in_ready  = (r_state == IDLE);
  assign b.out_valid = r_ovalid;
  assign b.x_out     = r_x_out;
  assign b.y_out     = r_y_out;
  assign b.range_err = r_rerr;

  // Fold out-of-range angles onto the nearest legal quadrant edge
  always_comb begin
    w_z_cl    = b.z0;
    w_clamped = 1'b0;
    if (int'(b.z0) > ANGLE_HALF_PI) begin
      w_z_cl    = WIDTH'(ANGLE_HALF_PI);
      w_clamped = 1'b1;
    end else if (int'(b.z0) < -ANGLE_HALF_PI) begin
      w_z_cl    = WIDTH'(-ANGLE_HALF_PI);
      w_clamped = 1'b1;
    end
  end

  cordic_micro_rot #(
    .IW(IW),
    .ZW(WIDTH)
  ) u_rot (
    .i_x(r_x),
    .i_y(r_y),
    .i_z(r_z),
    .i_i(r_i),
    .o_x(w_x_n),
    .o_y(w_y_n),
    .o_z(w_z_n)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      IDLE:    if (w_acc)  w_state_n = ROTATE;
      ROTATE:  if (w_last) w_state_n = DONE;
      DONE:    if (w_xfer) w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x      <= '0;
      r_y      <= '0;
      r_z      <= '0;
      r_i      <= '0;
      r_x_out  <= '0;
      r_y_out  <= '0;
      r_rerr   <= 1'b0;
      r_ovalid <= 1'b0;
    end else if (w_acc) begin
      r_x    <= IW'(b.x0);
      r_y    <= IW'(b.y0);
      r_z    <= w_z_cl;
      r_i    <= '0;
      r_rerr <= w_clamped;
    end else if (r_state == ROTATE) begin
      r_x <= w_x_n;
      r_y <= w_y_n;
      r_z <= w_z_n;
      r_i <= r_i + 3'd1;
      if (w_last) begin
        r_x_out  <= WIDTH'(sat(32'(w_x_n), WIDTH));
        r_y_out  <= WIDTH'(sat(32'(w_y_n), WIDTH));
        r_ovalid <= 1'b1;
      end
    end else if (w_xfer) begin
      r_ovalid <= 1'b0;
    end
  end

endmodule
